boot_loader: RTL and testbench

- Bus initiator that fills the 8 KB boot program RAM over the b16 memory-bus signals (sel, r, w[1:0], addr[12:1], data) from a host byte stream, e.g. a UART receiver.
- Parses a frame (header, payload, checksum), writes byte lanes directly, then reads the loaded region back and verifies it.
- Holds the CPU in reset until a load completes cleanly; sits between the host link and the boot RAM port.

---
 rtl/boot_loader_pkg.sv | 23 ++
 rtl/boot_loader_sum.sv | 40 ++++
 rtl/boot_loader.sv | 261 ++++++++++++++++++++++++++
 tb/tb_boot_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot RAM loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StCsum,
        StVerify,
        StVdrain,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_RDBK = 2'b11;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned CSUM_BYTES = 2;

endpackage

// File: rtl/boot_loader_sum.sv
// 16-bit modular accumulator: adds a low byte, a high byte (x256) or a full word.
module boot_loader_sum (
    input  logic        i_clk,
    input  logic        i_nreset,
    input  logic        i_clr,
    input  logic        i_add_lo,
    input  logic        i_add_hi,
    input  logic        i_add_word,
    input  logic [7:0]  i_byte,
    input  logic [15:0] i_word,
    output logic [15:0] o_sum
);

    logic [15:0] r_sum;
    logic [15:0] w_sum_nxt;

    always_comb begin
        w_sum_nxt = r_sum;
        if (i_clr) begin
            w_sum_nxt = '0;
        end else if (i_add_word) begin
            w_sum_nxt = r_sum + i_word;
        end else if (i_add_hi) begin
            w_sum_nxt = r_sum + {i_byte, 8'h00};
        end else if (i_add_lo) begin
            w_sum_nxt = r_sum + {8'h00, i_byte};
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/boot_loader.sv
// Frame parser and bus initiator that loads the boot RAM, reads it back and
// releases the CPU only after a clean load.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned AW     = 12,
    parameter int unsigned MAXCNT = 4096
) (
    input  logic          i_clk,
    input  logic          i_nreset,
    input  logic          i_start,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    output logic          o_rx_ready,
    output logic          o_mem_sel,
    output logic          o_mem_r,
    output logic [1:0]    o_mem_w,
    output logic [AW-1:0] o_mem_addr,
    output logic [15:0]   o_mem_wdata,
    input  logic [15:0]   i_mem_rdata,
    output logic          o_busy,
    output logic          o_done,
    output logic [1:0]    o_err,
    output logic          o_cpu_hold
);

    state_e        r_state, w_state_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_lo_byte, w_lo_byte_nxt;
    logic [AW-1:0] r_start, w_start_nxt;
    logic [AW-1:0] r_addr, w_addr_nxt;
    logic [15:0]   r_n, w_n_nxt;
    logic [15:0]   r_left, w_left_nxt;
    logic          r_hi, w_hi_nxt;
    logic          r_mem_sel, w_mem_sel_nxt;
    logic          r_mem_r, w_mem_r_nxt;
    logic [1:0]    r_mem_w, w_mem_w_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [15:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic          r_done, w_done_nxt;
    logic [1:0]    r_err, w_err_nxt;
    logic          r_cpu_hold, w_cpu_hold_nxt;
    logic          r_rd_pend;

    logic          w_rx_ready, w_acc;
    logic [15:0]   w_word16;
    logic          w_clr, w_e_lo, w_e_hi;
    logic [15:0]   w_e_sum, w_r_sum, w_r_final;

    assign w_rx_ready = (r_state inside {StHdr, StData, StCsum});
    assign w_acc      = i_rx_valid & w_rx_ready;
    assign w_word16   = {i_rx_data, r_lo_byte};
    // Readback total including the word that lands during VDRAIN.
    assign w_r_final  = w_r_sum + i_mem_rdata;

    boot_loader_sum u_sum_e (
        .i_clk      (i_clk),
        .i_nreset   (i_nreset),
        .i_clr      (w_clr),
        .i_add_lo   (w_e_lo),
        .i_add_hi   (w_e_hi),
        .i_add_word (1'b0),
        .i_byte     (i_rx_data),
        .i_word     (16'h0000),
        .o_sum      (w_e_sum)
    );

    boot_loader_sum u_sum_r (
        .i_clk      (i_clk),
        .i_nreset   (i_nreset),
        .i_clr      (w_clr),
        .i_add_lo   (1'b0),
        .i_add_hi   (1'b0),
        .i_add_word (r_rd_pend),
        .i_byte     (8'h00),
        .i_word     (i_mem_rdata),
        .o_sum      (w_r_sum)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_lo_byte_nxt   = r_lo_byte;
        w_start_nxt     = r_start;
        w_addr_nxt      = r_addr;
        w_n_nxt         = r_n;
        w_left_nxt      = r_left;
        w_hi_nxt        = r_hi;
        w_mem_sel_nxt   = 1'b0;
        w_mem_r_nxt     = 1'b1;
        w_mem_w_nxt     = 2'b00;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;
        w_cpu_hold_nxt  = r_cpu_hold;
        w_clr           = 1'b0;
        w_e_lo          = 1'b0;
        w_e_hi          = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_nxt    = StHdr;
                    w_idx_nxt      = '0;
                    w_done_nxt     = 1'b0;
                    w_err_nxt      = ERR_NONE;
                    w_cpu_hold_nxt = 1'b1;
                    w_clr          = 1'b1;
                end
            end
            StHdr: begin
                if (w_acc) begin
                    w_idx_nxt = r_idx + 2'd1;
                    if (!r_idx[0]) begin
                        w_lo_byte_nxt = i_rx_data;
                    end else if (r_idx != 2'(HDR_BYTES - 1)) begin
                        w_start_nxt = w_word16[AW-1:0];
                        w_addr_nxt  = w_word16[AW-1:0];
                    end else begin
                        w_n_nxt    = w_word16;
                        w_left_nxt = w_word16;
                        w_hi_nxt   = 1'b0;
                        if (w_word16 > 16'(MAXCNT)) begin
                            w_state_nxt = StErr;
                            w_err_nxt   = ERR_LEN;
                        end else if (w_word16 == 16'd0) begin
                            w_state_nxt = StCsum;
                        end else begin
                            w_state_nxt = StData;
                        end
                    end
                end
            end
            StData: begin
                if (w_acc) begin
                    w_mem_sel_nxt   = 1'b1;
                    w_mem_r_nxt     = 1'b0;
                    w_mem_addr_nxt  = r_addr;
                    w_mem_wdata_nxt = {i_rx_data, i_rx_data};
                    w_hi_nxt        = ~r_hi;
                    if (!r_hi) begin
                        w_mem_w_nxt = 2'b01;
                        w_e_lo      = 1'b1;
                    end else begin
                        w_mem_w_nxt = 2'b10;
                        w_e_hi      = 1'b1;
                        w_addr_nxt  = r_addr + AW'(1);
                        w_left_nxt  = r_left - 16'd1;
                        if (r_left == 16'd1) begin
                            w_state_nxt = StCsum;
                        end
                    end
                end
            end
            StCsum: begin
                if (w_acc) begin
                    w_idx_nxt = r_idx + 2'd1;
                    if (r_idx != 2'(CSUM_BYTES - 1)) begin
                        w_lo_byte_nxt = i_rx_data;
                    end else if (w_word16 != w_e_sum) begin
                        w_state_nxt = StErr;
                        w_err_nxt   = ERR_CSUM;
                    end else if (r_n == 16'd0) begin
                        w_state_nxt    = StDone;
                        w_done_nxt     = 1'b1;
                        w_cpu_hold_nxt = 1'b0;
                    end else begin
                        // First readback address goes out with the VERIFY entry.
                        w_state_nxt    = StVerify;
                        w_mem_sel_nxt  = 1'b1;
                        w_mem_addr_nxt = r_start;
                        w_addr_nxt     = r_start + AW'(1);
                        w_left_nxt     = r_n - 16'd1;
                    end
                end
            end
            StVerify: begin
                if (r_left != 16'd0) begin
                    w_mem_sel_nxt  = 1'b1;
                    w_mem_addr_nxt = r_addr;
                    w_addr_nxt     = r_addr + AW'(1);
                    w_left_nxt     = r_left - 16'd1;
                end else begin
                    w_state_nxt = StVdrain;
                end
            end
            StVdrain: begin
                if (w_r_final != w_e_sum) begin
                    w_state_nxt = StErr;
                    w_err_nxt   = ERR_RDBK;
                end else begin
                    w_state_nxt    = StDone;
                    w_done_nxt     = 1'b1;
                    w_cpu_hold_nxt = 1'b0;
                end
            end
            StDone, StErr: begin
                if (i_start) begin
                    w_state_nxt    = StIdle;
                    w_done_nxt     = 1'b0;
                    w_err_nxt      = ERR_NONE;
                    w_cpu_hold_nxt = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_state     <= StIdle;
            r_idx       <= '0;
            r_lo_byte   <= '0;
            r_start     <= '0;
            r_addr      <= '0;
            r_n         <= '0;
            r_left      <= '0;
            r_hi        <= 1'b0;
            r_mem_sel   <= 1'b0;
            r_mem_r     <= 1'b1;
            r_mem_w     <= 2'b00;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= ERR_NONE;
            r_cpu_hold  <= 1'b1;
            r_rd_pend   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_lo_byte   <= w_lo_byte_nxt;
            r_start     <= w_start_nxt;
            r_addr      <= w_addr_nxt;
            r_n         <= w_n_nxt;
            r_left      <= w_left_nxt;
            r_hi        <= w_hi_nxt;
            r_mem_sel   <= w_mem_sel_nxt;
            r_mem_r     <= w_mem_r_nxt;
            r_mem_w     <= w_mem_w_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
            r_cpu_hold  <= w_cpu_hold_nxt;
            r_rd_pend   <= r_mem_sel & r_mem_r;
        end
    end

    assign o_rx_ready  = w_rx_ready;
    assign o_mem_sel   = r_mem_sel;
    assign o_mem_r     = r_mem_r;
    assign o_mem_w     = r_mem_w;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = (r_state inside {StHdr, StData, StCsum, StVerify, StVdrain});
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_cpu_hold  = r_cpu_hold;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table frames, hand-made corner cases and
// random frames against a frame-level model of bus traffic and result flags.
module tb_boot_loader;

    localparam int AW = 12;
    localparam int WORDS = 4096;

    logic          clk = 1'b0;
    logic          nreset;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_sel;
    logic          mem_r;
    logic [1:0]    mem_w;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   rdata = 16'h0000;
    logic          busy;
    logic          done;
    logic [1:0]    err;
    logic          cpu_hold;

    boot_loader #(.AW(AW), .MAXCNT(4096)) dut (
        .i_clk       (clk),
        .i_nreset    (nreset),
        .i_start     (start),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .o_rx_ready  (rx_ready),
        .o_mem_sel   (mem_sel),
        .o_mem_r     (mem_r),
        .o_mem_w     (mem_w),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (rdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_cpu_hold  (cpu_hold)
    );

    always #5 clk = ~clk;

    // Boot RAM model: byte-lane writes, read data one cycle after the address.
    logic [15:0]   ram [WORDS];
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;

    always @(posedge clk) begin
        if (mem_sel && !mem_r) begin
            if (mem_w[0]) ram[mem_addr][7:0] <= mem_wdata[7:0];
            if (mem_w[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
        end
        if (mem_sel && mem_r) begin
            rdata <= ram[mem_addr] ^ ((corrupt_en && mem_addr == corrupt_addr) ? 16'h0040 : 16'h0000);
        end
    end

    typedef struct packed {
        logic          r;
        logic [1:0]    w;
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } bus_t;

    bus_t obs_q[$];
    int   viol = 0;

    always @(negedge clk) begin
        if (mem_sel) obs_q.push_back({mem_r, mem_w, mem_addr, mem_r ? 16'h0000 : mem_wdata});
        if (mem_w != 2'b00 && (mem_r || !mem_sel)) viol++;
    end

    int          n_vec = 0;
    int          n_bad = 0;
    bit          at_idle = 1'b1;
    bit          abort = 1'b0;
    bit          start_noise = 1'b0;
    int          last_base = 0;
    logic [15:0] payload[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic bus_t mk(input logic r, input logic [1:0] w, input logic [AW-1:0] a,
                                input logic [15:0] d);
        return {r, w, a, d};
    endfunction

    function automatic logic [1:0] model_err(input int n, input logic [15:0] csum, input bit corrupt);
        logic [15:0] s = 16'h0000;
        if (n > WORDS) return 2'b01;
        foreach (payload[i]) s = s + payload[i];
        if (s != csum) return 2'b10;
        if (corrupt && n >= 2) return 2'b11;
        return 2'b00;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (abort) return;
        for (int g = 0; g < gap; g++) begin
            start = start_noise && (g == 0);
            @(negedge clk);
            start = 1'b0;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) begin
            check("byte_accept_timeout", 32'(rx_ready), 32'd1);
            abort    = 1'b1;
            rx_valid = 1'b0;
            return;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [AW-1:0] addr, input int n,
                             input logic [15:0] csum, input int max_gap, input bit corrupt,
                             input logic [1:0] exp_err);
        bus_t        exp_q[$];
        bus_t        first_act, first_exp;
        int          base, t, nm, cnt;
        logic [15:0] w;
        logic [AW-1:0] a;
        logic [15:0] n16 = 16'(n);
        abort = 1'b0;
        if (n <= WORDS) begin
            for (int i = 0; i < n; i++) begin
                a = AW'(int'(addr) + i);
                w = payload[i];
                exp_q.push_back(mk(1'b0, 2'b01, a, {w[7:0], w[7:0]}));
                exp_q.push_back(mk(1'b0, 2'b10, a, {w[15:8], w[15:8]}));
            end
            if (exp_err == 2'b00 || exp_err == 2'b11) begin
                for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b1, 2'b00, AW'(int'(addr) + i), 16'h0000));
            end
        end
        if (!at_idle) begin
            pulse_start();
            check({name, "_clr_done"}, 32'(done), 32'd0);
            check({name, "_clr_err"}, 32'(err), 32'd0);
            check({name, "_clr_hold"}, 32'(cpu_hold), 32'd1);
        end
        pulse_start();
        check({name, "_busy"}, 32'(busy), 32'd1);
        base         = obs_q.size();
        last_base    = base;
        corrupt_en   = corrupt;
        corrupt_addr = AW'(int'(addr) + 1);
        send_byte(addr[7:0], $urandom_range(0, max_gap));
        send_byte({4'h0, addr[11:8]}, $urandom_range(0, max_gap));
        send_byte(n16[7:0], $urandom_range(0, max_gap));
        send_byte(n16[15:8], $urandom_range(0, max_gap));
        if (n <= WORDS) begin
            for (int i = 0; i < n; i++) begin
                w = payload[i];
                send_byte(w[7:0], $urandom_range(0, max_gap));
                send_byte(w[15:8], $urandom_range(0, max_gap));
            end
            send_byte(csum[7:0], $urandom_range(0, max_gap));
            send_byte(csum[15:8], $urandom_range(0, max_gap));
        end
        t = 0;
        while (busy && t < 20000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_finish"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'(exp_err == 2'b00));
        check({name, "_err"}, 32'(err), 32'(exp_err));
        check({name, "_hold"}, 32'(cpu_hold), 32'(exp_err != 2'b00));
        check({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
        cnt = obs_q.size() - base;
        check({name, "_bus_count"}, 32'(cnt), 32'(exp_q.size()));
        nm = 0;
        first_act = '0;
        first_exp = '0;
        for (int i = 0; i < exp_q.size() && i < cnt; i++) begin
            if (obs_q[base + i] !== exp_q[i]) begin
                if (nm == 0) begin
                    first_act = obs_q[base + i];
                    first_exp = exp_q[i];
                end
                nm++;
            end
        end
        n_vec++;
        if (nm != 0) begin
            n_bad++;
            $display("FAIL %s_bus_seq: %0d cycles differ, first got %h, expected %h", name, nm,
                     first_act, first_exp);
        end
        corrupt_en = 1'b0;
        at_idle    = 1'b0;
    endtask

    typedef struct {
        string         name;
        logic [AW-1:0] addr;
        int            n;
        logic [63:0]   words;
        logic [15:0]   csum;
        int            max_gap;
        bit            corrupt;
        logic [1:0]    exp_err;
    } vec_t;

    vec_t tbl[7];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        bus_t        e;
        logic [15:0] s;
        logic [1:0]  me;
        int          n;
        bit          bad;
        tbl[0] = '{"v0_basic",   12'h010, 2,      64'h0000_0000_ABCD_1234, 16'hBE01, 0, 1'b0, 2'b00};
        tbl[1] = '{"v1_badcsum", 12'h010, 2,      64'h0000_0000_ABCD_1234, 16'hBE02, 0, 1'b0, 2'b10};
        tbl[2] = '{"v2_wrap",    12'hFFF, 2,      64'h0000_0000_0002_0001, 16'h0003, 0, 1'b0, 2'b00};
        tbl[3] = '{"v3_toolong", 12'h000, 'h1001, 64'h0,                   16'h0000, 0, 1'b0, 2'b01};
        tbl[4] = '{"v4_empty",   12'h000, 0,      64'h0,                   16'h0000, 0, 1'b0, 2'b00};
        tbl[5] = '{"v5_rdbk",    12'h100, 3,      64'h0000_8001_FF00_00FF, 16'h8000, 0, 1'b1, 2'b11};
        tbl[6] = '{"v6_gaps",    12'h7F0, 3,      64'h0000_8001_FF00_00FF, 16'h8000, 5, 1'b0, 2'b00};

        nreset   = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(mem_sel), 32'd0);
        check("rst_r", 32'(mem_r), 32'd1);
        check("rst_w", 32'(mem_w), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wdata), 32'd0);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        nreset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            payload.delete();
            for (int i = 0; i < tbl[v].n && i < 4; i++) payload.push_back(tbl[v].words[16*i +: 16]);
            run_frame(tbl[v].name, tbl[v].addr, tbl[v].n, tbl[v].csum, tbl[v].max_gap,
                      tbl[v].corrupt, tbl[v].exp_err);
            if (v == 0) begin
                for (int i = 0; i < 4; i++) begin
                    case (i)
                        0: e = mk(1'b0, 2'b01, 12'h010, 16'h3434);
                        1: e = mk(1'b0, 2'b10, 12'h010, 16'h1212);
                        2: e = mk(1'b0, 2'b01, 12'h011, 16'hCDCD);
                        default: e = mk(1'b0, 2'b10, 12'h011, 16'hABAB);
                    endcase
                    check("v0_write", 32'((last_base + i < obs_q.size()) ? obs_q[last_base + i] : '0), 32'(e));
                end
                check("v0_ram0", 32'(ram[12'h010]), 32'h1234);
                check("v0_ram1", 32'(ram[12'h011]), 32'hABCD);
            end
        end

        // Reset sampled on the same edge that would accept the third DATA byte.
        pulse_start();
        pulse_start();
        abort = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        check("mid_ready", 32'(rx_ready), 32'd1);
        rx_data  = 8'h33;
        rx_valid = 1'b1;
        nreset   = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        check("mid_rst_sel", 32'(mem_sel), 32'd0);
        check("mid_rst_w", 32'(mem_w), 32'd0);
        check("mid_rst_r", 32'(mem_r), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(rx_ready), 32'd0);
        check("mid_rst_hold", 32'(cpu_hold), 32'd1);
        nreset = 1'b1;
        @(negedge clk);
        at_idle = 1'b1;

        start_noise = 1'b1;
        for (int f = 0; f < 14; f++) begin
            payload.delete();
            n = $urandom_range(1, 8);
            s = 16'h0000;
            for (int i = 0; i < n; i++) begin
                payload.push_back(16'($urandom));
                s = s + payload[i];
            end
            bad = ($urandom_range(0, 3) == 0);
            if (bad) s = s + 16'($urandom_range(1, 255));
            me = model_err(n, s, $urandom_range(0, 3) == 0);
            run_frame($sformatf("rnd%0d", f), AW'($urandom), n, s, $urandom_range(0, 5),
                      me == 2'b11, me);
        end
        start_noise = 1'b0;

        payload.delete();
        s = 16'h0000;
        for (int i = 0; i < WORDS; i++) begin
            payload.push_back(16'($urandom));
            s = s + payload[i];
        end
        run_frame("maxcnt", 12'h800, WORDS, s, 0, 1'b0, model_err(WORDS, s, 1'b0));

        check("bus_rules", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
